// File: rtl/ul4_pkg.sv
// Shared definitions for the ul4 logic unit and its sequential front-end:
// operation select codes and the FSM state encoding.
package ul4_pkg;

  // ul4 operation select codes
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : ul4_pkg

// File: rtl/ul4.sv
// ul4: purely combinational 4-bit logic unit (AND / OR / XOR / NOT A).
module ul4
  import ul4_pkg::*;
(
  output logic [3:0] Out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] S
);

  // Select the logic function; NOT ignores operand B.
  always_comb begin
    Out = 4'b0000;
    case (S)
      OP_AND:  Out = A & B;
      OP_OR:   Out = A | B;
      OP_XOR:  Out = A ^ B;
      OP_NOT:  Out = ~A;
      default: Out = 4'b0000;
    endcase
  end

endmodule : ul4

// File: rtl/ul4_acc_seq.sv
// ul4_acc_seq: accumulator front-end for ul4. Loads an accumulator, then applies
// one latched ul4 operation n times (acc <= ul4(acc, b, op)) under a
// start/busy/done handshake. The accumulator is also ul4 operand A.
module ul4_acc_seq
  import ul4_pkg::*;
#(
  parameter int         CNT_W     = 3,
  parameter logic [3:0] ACC_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [3:0]       din,
  input  logic             start,
  input  logic [3:0]       b_in,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] n,
  output logic [3:0]       acc,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [3:0]       b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ul4_out_s;

  // Operand A is always the live accumulator; B and S come from the start-time latches.
  ul4 u_ul4 (
    .Out (ul4_out_s),
    .A   (acc_q),
    .B   (b_q),
    .S   (op_q)
  );

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= ACC_RESET;
      b_q     <= 4'b0000;
      op_q    <= 2'b00;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          // load has priority; a simultaneous start is dropped
          acc_d   = din;
          state_d = ST_IDLE;
        end else if (start) begin
          b_d  = b_in;
          op_d = op;
          cnt_d = n;
          if (n != CNT_ZERO) begin
            state_d = ST_RUN;
          end else begin
            // zero iterations: report completion without touching acc
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // cnt is at least 1 here, so the decrement never wraps
        acc_d = ul4_out_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from registers: no extra latency, glitch-free status.
  always_comb begin
    acc  = acc_q;
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    zero = (acc_q == 4'b0000);
  end

endmodule : ul4_acc_seq

// File: tb/tb_ul4_acc_seq.sv
// Directed self-checking bench for ul4_acc_seq: reset, load, iteration timing,
// n==0, ignored inputs while busy, reset abort and a full n=1 operation sweep.
module tb_ul4_acc_seq;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] din;
  logic       start;
  logic [3:0] b_in;
  logic [1:0] op;
  logic [2:0] n;
  logic [3:0] acc;
  logic       busy;
  logic       done;
  logic       zero;

  int errors;
  int checks;

  ul4_acc_seq #(.CNT_W(3), .ACC_RESET(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .start (start),
    .b_in  (b_in),
    .op    (op),
    .n     (n),
    .acc   (acc),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ul4 behaviour written from the operation table.
  function automatic logic [3:0] ref_ul4(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic status(input string tag, input logic [3:0] e_acc,
                        input logic e_busy, input logic e_done);
    check({tag, "_acc"},  acc, e_acc);
    check({tag, "_busy"}, {3'b000, busy}, {3'b000, e_busy});
    check({tag, "_done"}, {3'b000, done}, {3'b000, e_done});
    check({tag, "_zero"}, {3'b000, zero}, {3'b000, (e_acc == 4'b0000)});
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_acc(input logic [3:0] v);
    load = 1'b1;
    din  = v;
    step();
    load = 1'b0;
  endtask

  // Pulse start for one edge (E0); returns just after E0.
  task automatic start_seq(input logic [1:0] o, input logic [3:0] b, input logic [2:0] cnt);
    start = 1'b1;
    op    = o;
    b_in  = b;
    n     = cnt;
    step();
    start = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    load   = 1'b0;
    din    = 4'b0000;
    start  = 1'b0;
    b_in   = 4'b0000;
    op     = 2'b00;
    n      = 3'd0;

    // 1: reset for one cycle
    step();
    reset = 1'b0;
    status("t1_reset", 4'b0000, 1'b0, 1'b0);

    // 2: load 1010, XOR 0110 once -> 1100
    load_acc(4'b1010);
    status("t2_load", 4'b1010, 1'b0, 1'b0);
    start_seq(2'b10, 4'b0110, 3'd1);
    status("t2_e0", 4'b1010, 1'b1, 1'b0);
    step();
    status("t2_e1", 4'b1100, 1'b1, 1'b1);
    step();
    status("t2_e2", 4'b1100, 1'b0, 1'b0);

    // 3: NOT three times from 0101
    load_acc(4'b0101);
    start_seq(2'b11, 4'b0000, 3'd3);
    status("t3_e0", 4'b0101, 1'b1, 1'b0);
    step();
    status("t3_e1", 4'b1010, 1'b1, 1'b0);
    step();
    status("t3_e2", 4'b0101, 1'b1, 1'b0);
    step();
    status("t3_e3", 4'b1010, 1'b1, 1'b1);
    step();
    status("t3_e4", 4'b1010, 1'b0, 1'b0);
    // NOT twice returns to the start value
    load_acc(4'b0101);
    start_seq(2'b11, 4'b1111, 3'd2);
    step();
    status("t3b_e1", 4'b1010, 1'b1, 1'b0);
    step();
    status("t3b_e2", 4'b0101, 1'b1, 1'b1);
    step();
    status("t3b_e3", 4'b0101, 1'b0, 1'b0);

    // 4: AND with zero clears the accumulator
    load_acc(4'b1111);
    start_seq(2'b00, 4'b0000, 3'd1);
    status("t4_e0", 4'b1111, 1'b1, 1'b0);
    step();
    status("t4_e1", 4'b0000, 1'b1, 1'b1);
    step();
    status("t4_e2", 4'b0000, 1'b0, 1'b0);

    // 5: n==0 gives a single-cycle done, acc untouched
    load_acc(4'b0011);
    start_seq(2'b11, 4'b1111, 3'd0);
    status("t5_e0", 4'b0011, 1'b1, 1'b1);
    step();
    status("t5_e1", 4'b0011, 1'b0, 1'b0);

    // 6a: pulses while busy are ignored, counter keeps its latched value
    load_acc(4'b0000);
    start_seq(2'b10, 4'b0001, 3'd3);
    start = 1'b1; load = 1'b1; din = 4'b1111; b_in = 4'b1111; op = 2'b00; n = 3'd7;
    step();
    status("t6a_e1", 4'b0001, 1'b1, 1'b0);
    start = 1'b0; load = 1'b0;
    step();
    status("t6a_e2", 4'b0000, 1'b1, 1'b0);
    step();
    status("t6a_e3", 4'b0001, 1'b1, 1'b1);
    step();
    status("t6a_e4", 4'b0001, 1'b0, 1'b0);

    // 6b: reset mid-RUN aborts with no done pulse
    load_acc(4'b0110);
    start_seq(2'b01, 4'b0001, 3'd7);
    start = 1'b1; load = 1'b1; din = 4'b1111; b_in = 4'b1000; op = 2'b00; n = 3'd0;
    step();
    status("t6b_e1", 4'b0111, 1'b1, 1'b0);
    start = 1'b0; load = 1'b0;
    step();
    status("t6b_e2", 4'b0111, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    status("t6b_e3", 4'b0000, 1'b0, 1'b0);
    step();
    status("t6b_e4", 4'b0000, 1'b0, 1'b0);

    // Sweep every acc x b x op with n=1 against the reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 4; s++) begin
          load_acc(4'(a));
          start_seq(2'(s), 4'(b), 3'd1);
          step();
          check($sformatf("sweep_a%0d_b%0d_s%0d", a, b, s), acc,
                ref_ul4(4'(a), 4'(b), 2'(s)));
          check("sweep_done", {3'b000, done}, 4'b0001);
          step();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ul4_acc_seq
